// File: rtl/bayer_bin_rgb_if.sv
// ----------------------------------------------------------------------
// bayer_bin_rgb_if : raw Bayer input stream and binned RGB output stream
// Revision: 1.0
// ----------------------------------------------------------------------
`default_nettype none

interface bayer_bin_rgb_if #(
    parameter int DW = 12
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [10:0]   in_x;
    logic [10:0]   in_y;

    logic          valid;
    logic [DW-1:0] pixel_r;
    logic [DW-1:0] pixel_g;
    logic [DW-1:0] pixel_b;
    logic [9:0]    x_cntr;
    logic [9:0]    y_cntr;

    // master drives raw samples and observes RGB; slave is the binning stage
    modport master (
        output in_valid, in_data, in_x, in_y,
        input  valid, pixel_r, pixel_g, pixel_b, x_cntr, y_cntr
    );

    modport slave (
        input  in_valid, in_data, in_x, in_y,
        output valid, pixel_r, pixel_g, pixel_b, x_cntr, y_cntr
    );
endinterface

`default_nettype wire

// File: rtl/bayer_bin_rgb.sv
// ----------------------------------------------------------------------
// bayer_bin_rgb : 2x2 binning of a 12-bit GRBG raw stream to half-res RGB
// Revision: 1.0
// ----------------------------------------------------------------------
`default_nettype none

module bayer_bin_rgb #(
    parameter int IN_W = 1280,
    parameter int DW   = 12
) (
    input  logic           clk,
    input  logic           rst,
    bayer_bin_rgb_if.slave bus
);
    localparam int          c_aw   = $clog2(IN_W);
    localparam logic [10:0] c_in_w = 11'(IN_W);

    logic [DW-1:0] linebuf [IN_W];
    logic [DW-1:0] rd_q;

    logic          pair_q, pair_d;
    logic [9:0]    pair_col_q, pair_col_d;
    logic [DW-1:0] b_q, b_d;
    logic          even_seen_q, even_seen_d;

    logic          s1_vld_q;
    logic [DW-1:0] s1_g1_q, s1_g2_q, s1_b_q;
    logic [9:0]    s1_x_q, s1_y_q;

    logic          s2_vld_q;
    logic [DW-1:0] s2_r_q, s2_g_q, s2_b_q;
    logic [9:0]    s2_x_q, s2_y_q;

    logic          vld_q;
    logic [DW-1:0] r_q, g_q, bo_q;
    logic [9:0]    x_q, y_q;

    logic          w_acc, w_wr, w_even_col, w_odd_col, w_form;
    logic [c_aw-1:0] w_addr;
    logic [DW-1:0] g_d;

    assign w_acc      = !rst && bus.in_valid && (bus.in_x < c_in_w);
    assign w_wr       = w_acc && !bus.in_y[0];
    assign w_even_col = w_acc &&  bus.in_y[0] && !bus.in_x[0];
    assign w_odd_col  = w_acc &&  bus.in_y[0] &&  bus.in_x[0];
    assign w_form     = w_odd_col && pair_q && even_seen_q
                        && (bus.in_x[10:1] == pair_col_q);
    assign w_addr     = bus.in_x[c_aw-1:0];
    assign g_d        = DW'(({1'b0, s1_g1_q} + {1'b0, s1_g2_q}) >> 1);

    always_comb begin
        pair_d      = pair_q;
        pair_col_d  = pair_col_q;
        b_d         = b_q;
        even_seen_d = even_seen_q;
        if (w_wr) begin
            even_seen_d = 1'b1;
        end
        if (w_even_col) begin
            pair_d     = 1'b1;
            pair_col_d = bus.in_x[10:1];
            b_d        = bus.in_data;
        end else if (w_odd_col) begin
            pair_d = 1'b0;
        end
    end

    // Single-port line buffer: writes on even rows, reads on odd rows.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            linebuf[w_addr] <= bus.in_data;
        end else if (w_even_col || w_odd_col) begin
            rd_q <= linebuf[w_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pair_q      <= 1'b0;
            even_seen_q <= 1'b0;
            s1_vld_q    <= 1'b0;
            s2_vld_q    <= 1'b0;
            vld_q       <= 1'b0;
            r_q         <= '0;
            g_q         <= '0;
            bo_q        <= '0;
            x_q         <= '0;
            y_q         <= '0;
        end else begin
            pair_q      <= pair_d;
            even_seen_q <= even_seen_d;
            s1_vld_q    <= w_form;
            s2_vld_q    <= s1_vld_q;
            vld_q       <= s2_vld_q;
            if (s2_vld_q) begin
                r_q  <= s2_r_q;
                g_q  <= s2_g_q;
                bo_q <= s2_b_q;
                x_q  <= s2_x_q;
                y_q  <= s2_y_q;
            end
        end
    end

    // rd_q holds G1 when the odd/odd sample lands and R one cycle later.
    always_ff @(posedge clk) begin
        pair_col_q <= pair_col_d;
        b_q        <= b_d;
        if (w_form) begin
            s1_g1_q <= rd_q;
            s1_g2_q <= bus.in_data;
            s1_b_q  <= b_q;
            s1_x_q  <= pair_col_q;
            s1_y_q  <= bus.in_y[10:1];
        end
        if (s1_vld_q) begin
            s2_r_q <= rd_q;
            s2_g_q <= g_d;
            s2_b_q <= s1_b_q;
            s2_x_q <= s1_x_q;
            s2_y_q <= s1_y_q;
        end
    end

    assign bus.valid   = vld_q;
    assign bus.pixel_r = r_q;
    assign bus.pixel_g = g_q;
    assign bus.pixel_b = bo_q;
    assign bus.x_cntr  = x_q;
    assign bus.y_cntr  = y_q;

endmodule

`default_nettype wire

// File: tb/tb_bayer_bin_rgb.sv
// ----------------------------------------------------------------------
// tb_bayer_bin_rgb : scoreboard bench for the 2x2 Bayer binning stage
// Revision: 1.0
// ----------------------------------------------------------------------
`default_nettype none

module tb_bayer_bin_rgb;
    localparam int IN_W     = 1280;
    localparam int DW       = 12;
    localparam int ROWS     = 8;
    localparam int FRAME_PX = (IN_W / 2) * (ROWS / 2);

    typedef struct {
        logic [DW-1:0] r, g, b;
        logic [9:0]    x, y;
        int            cyc;
    } exp_t;

    typedef struct {
        logic [DW-1:0] g1, r, b, g2;
        int            cx, cy;
        logic [DW-1:0] er, eg, eb;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bayer_bin_rgb_if #(.DW(DW)) bus ();

    bayer_bin_rgb #(.IN_W(IN_W), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t q[$];
    exp_t hold;
    int   cyc     = 0;
    int   n_chk   = 0;
    int   n_pass  = 0;
    int   n_pulse = 0;
    bit   mon_en  = 1'b0;
    vec_t vecs[6];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Output monitor: pulses are popped from the scoreboard, idle cycles must hold.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.valid === 1'b1) begin
                n_pulse++;
                if (q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_pulse: got pulse x=%0d y=%0d required none (cycle %0d)",
                             bus.x_cntr, bus.y_cntr, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
                    chk("pulse_data",
                        {bus.x_cntr, bus.y_cntr, bus.pixel_r, bus.pixel_g, bus.pixel_b},
                        {e.x, e.y, e.r, e.g, e.b});
                    hold = e;
                end
            end else begin
                chk("idle_hold",
                    {bus.valid, bus.x_cntr, bus.y_cntr, bus.pixel_r, bus.pixel_g, bus.pixel_b},
                    {1'b0, hold.x, hold.y, hold.r, hold.g, hold.b});
                if (q.size() > 0 && q[0].cyc <= cyc) begin
                    n_chk++;
                    $display("FAIL missing_pulse: got valid=0 required pulse x=%0d y=%0d (cycle %0d)",
                             q[0].x, q[0].y, cyc);
                    void'(q.pop_front());
                end
            end
        end
    end

    function automatic logic [DW-1:0] d(input int x, input int y);
        return DW'((x + y) & 32'hFFF);
    endfunction

    task automatic put(input int x, input int y, input logic [DW-1:0] v, input bit vld);
        bus.in_valid = vld;
        bus.in_x     = 11'(x);
        bus.in_y     = 11'(y);
        bus.in_data  = v;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        put(int'($urandom_range(2047)), int'($urandom_range(2047)), DW'($urandom), 1'b0);
    endtask

    task automatic expect_px(input logic [DW-1:0] r, g, b, input int x, input int y);
        exp_t e;
        e.r = r; e.g = g; e.b = b;
        e.x = 10'(x); e.y = 10'(y);
        e.cyc = cyc + 2;
        q.push_back(e);
    endtask

    // One frame-pattern sample; odd/odd samples push a quad built from the pattern.
    task automatic smp(input int x, input int y, input bit ex);
        logic [DW:0] s;
        put(x, y, d(x, y), 1'b1);
        if (ex && (y % 2 == 1) && (x % 2 == 1)) begin
            s = {1'b0, d(x - 1, y - 1)} + {1'b0, d(x, y)};
            expect_px(d(x, y - 1), s[DW:1], d(x - 1, y), x / 2, y / 2);
        end
    endtask

    task automatic rows(input int y0, input int y1, input int x0, input int x1,
                        input int pct, input bit inject, input bit ex);
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) begin
                while (pct > 0 && $urandom_range(99) < pct) begin
                    if (inject && $urandom_range(3) == 0)
                        put(IN_W + int'($urandom_range(2047 - IN_W)), y, DW'($urandom), 1'b1);
                    else
                        idle();
                end
                smp(x, y, ex);
            end
        end
    endtask

    task automatic drain();
        repeat (8) idle();
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'($urandom);
            bus.in_x     = 11'($urandom);
            bus.in_y     = 11'($urandom);
            bus.in_data  = DW'($urandom);
            @(posedge clk);
            #1;
            q.delete();
            hold   = '{default: 0};
            mon_en = 1'b1;
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{12'h100, 12'hABC, 12'h123, 12'h301,   0,   0, 12'hABC, 12'h200, 12'h123};
        vecs[1] = '{12'hFFF, 12'h000, 12'h000, 12'hFFE,   1,   1, 12'h000, 12'hFFE, 12'h000};
        vecs[2] = '{12'h001, 12'hFFF, 12'hFFF, 12'h002, 639,   2, 12'hFFF, 12'h001, 12'hFFF};
        vecs[3] = '{12'hFFF, 12'h123, 12'h456, 12'hFFF,   5,   3, 12'h123, 12'hFFF, 12'h456};
        vecs[4] = '{12'h800, 12'h0F0, 12'h00F, 12'h7FF, 320, 200, 12'h0F0, 12'h7FF, 12'h00F};
        vecs[5] = '{12'h000, 12'h555, 12'hAAA, 12'h000, 100, 479, 12'h555, 12'h000, 12'hAAA};

        bus.in_valid = 1'b0;
        bus.in_x     = '0;
        bus.in_y     = '0;
        bus.in_data  = '0;

        // reset with random inputs, then two quiet cycles
        do_reset(3);
        repeat (2) idle();

        // hand-built quads from the vector table
        foreach (vecs[i]) begin
            put(2 * vecs[i].cx,     2 * vecs[i].cy,     vecs[i].g1, 1'b1);
            put(2 * vecs[i].cx + 1, 2 * vecs[i].cy,     vecs[i].r,  1'b1);
            put(2 * vecs[i].cx,     2 * vecs[i].cy + 1, vecs[i].b,  1'b1);
            put(2 * vecs[i].cx + 1, 2 * vecs[i].cy + 1, vecs[i].g2, 1'b1);
            expect_px(vecs[i].er, vecs[i].eg, vecs[i].eb, vecs[i].cx, vecs[i].cy);
            repeat (3) idle();
        end
        drain();

        // gapless frame
        n_pulse = 0;
        rows(0, ROWS - 1, 0, IN_W - 1, 0, 1'b0, 1'b1);
        drain();
        chk("frame_pulse_count", 64'(n_pulse), 64'(FRAME_PX));

        // same frame with 50% bubbles and out-of-range samples
        n_pulse = 0;
        rows(0, ROWS - 1, 0, IN_W - 1, 50, 1'b1, 1'b1);
        drain();
        chk("bubble_pulse_count", 64'(n_pulse), 64'(FRAME_PX));

        // reset in the middle of row 1; rest of row 1 must stay silent
        rows(0, 0, 0, IN_W - 1, 0, 1'b0, 1'b1);
        rows(1, 1, 0, 599, 0, 1'b0, 1'b1);
        do_reset(2);
        n_pulse = 0;
        rows(1, 1, 600, IN_W - 1, 0, 1'b0, 1'b0);
        repeat (4) idle();
        chk("post_reset_silent", 64'(n_pulse), 64'd0);
        rows(2, 3, 0, IN_W - 1, 0, 1'b0, 1'b1);
        drain();

        // pairing faults on row 3 (buffer still holds row 2)
        n_pulse = 0;
        smp(7, 3, 1'b0);
        smp(8, 3, 1'b0);
        smp(11, 3, 1'b0);
        repeat (4) idle();
        chk("orphan_no_pulse", 64'(n_pulse), 64'd0);
        smp(12, 3, 1'b0);
        smp(14, 3, 1'b0);
        smp(15, 3, 1'b1);
        smp(20, 3, 1'b0);
        put(1280, 3, 12'h5A5, 1'b1);
        put(1281, 3, 12'hA5A, 1'b1);
        idle();
        smp(21, 3, 1'b1);
        smp(22, 3, 1'b0);
        smp(23, 3, 1'b1);
        smp(23, 3, 1'b0);
        drain();
        chk("pairing_pulse_count", 64'(n_pulse), 64'd3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/bayer_bin_rgb.md
Name: bayer_bin_rgb

Overview:
- Upstream neighbour of the edge_detect stage.
- Converts the full-resolution 12-bit Bayer raw stream from the camera capture path (1280x960) into half-resolution RGB (640x480) by 2x2 binning.
- Output is the pixel_r/g/b, valid, x_cntr, y_cntr stream that edge_detect consumes.
- Buffers one even raw row, then emits one RGB pixel per 2x2 quad during the following odd row.

Parameters:
IN_W, 1280, raw input line width in pixels (even); line buffer depth
DW, 12, raw and per-channel output width

Ports:
clk  input  1  single clock, all logic rising-edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  raw sample qualifier, one sample per cycle when high
in_data  input  DW  raw Bayer sample
in_x  input  11  raw column, 0..IN_W-1
in_y  input  11  raw row
valid  output  1  one-cycle pulse per RGB output pixel
pixel_r  output  DW  red
pixel_g  output  DW  green, average of two greens
pixel_b  output  DW  blue
x_cntr  output  10  output column = quad in_x>>1
y_cntr  output  10  output row = quad in_y>>1

Behaviour:
- Reset behaviour:
  - On a clk edge with rst=1: valid, pixel_r/g/b, x_cntr, y_cntr become 0.
  - Pipeline valid bits, the pair flag and the even_seen flag are cleared.
  - Line buffer contents are not cleared.
- Bayer layout, fixed:
  - Even row: even col = G1, odd col = R.
  - Odd row: even col = B, odd col = G2.
- Even row (in_y[0]=0), in_valid=1, in_x<IN_W:
  - Write in_data to linebuf[in_x].
  - Set even_seen.
  - No output.
- Odd row, even col:
  - Latch B and pair column in_x[10:1].
  - Issue linebuf read of G1 at in_x.
  - Set pair flag.
- Odd row, odd col:
  - Forms a quad only if pair flag=1, in_x[10:1] matches the latched pair column, and even_seen=1.
  - Otherwise discard it: no output.
  - Issue linebuf read of R at in_x.
  - Clear pair flag in either case.
- Line buffer is a single-port synchronous RAM, IN_W x DW, 1-cycle read latency. Even-row writes and odd-row reads never coincide.
- Arithmetic:
  - g = (G1+G2)>>1, computed with a DW+1-bit sum, truncating; no overflow possible.
  - r = R, b = B, passed unmodified.
- Latency: the odd/odd sample accepted at edge N gives outputs updated at edge N+2, with valid=1 for exactly that one cycle.
- Between pulses, valid=0 and the pixel, x_cntr and y_cntr outputs hold their last values.
- Bubbles:
  - in_valid=0 cycles are ignored; there are no stalls or backpressure.
  - The pair flag persists across bubbles.
  - Results are identical to a gapless stream.
- in_x >= IN_W: the sample is ignored entirely (no write, no flag change).
- An odd-row even-col sample arriving while the pair flag is already set overwrites the latched B and pair column.
- Rows arrive in raster order. An even row after an odd row simply overwrites the buffer; no frame-level state beyond even_seen.
- Reset mid-frame:
  - In-flight quads are dropped.
  - Odd-row samples before the next even-row write produce no output, because even_seen=0.
- Output count per full frame: (IN_W/2) x (rows/2) pulses in raster order.
- Throughput: one pulse per 2 accepted odd-row samples at most.

Test Plan:
1. Reset: drive random inputs with rst=1 for 3 cycles -> valid=0, all pixel and counter outputs 0 on every cycle; no pulse for 2 cycles after release.
2. Single quad:
   - Stimulus: row 0 x0=0x100, x1=0xABC; row 1 x0=0x123, x1=0x301.
   - Required: valid pulses exactly 2 edges after x1/row1 is accepted; r=0xABC, g=0x200, b=0x123, x_cntr=0, y_cntr=0; valid=0 next cycle with values held.
3. Green truncation: G1=0xFFF, G2=0xFFE -> g=0xFFE; G1=0x001, G2=0x002 -> g=0x001.
4. Full frame:
   - Stimulus: 1280x960 with in_data = (in_x+in_y)&0xFFF, continuous in_valid.
   - Required: exactly 307200 pulses; first at (0,0), last at x_cntr=639, y_cntr=479; every pulse matches the reference model.
5. Bubbles: same frame with in_valid randomly low 50% of cycles -> identical output sequence and count; in_x=1280 samples injected are ignored.
6. Reset and pairing faults:
   - Assert rst in the middle of row 1, then resume row 1 -> no pulses until row 2 is written; row 3 produces correct output.
   - An odd-col sample without a preceding even-col sample -> no pulse.
